// File: rtl/dds_hop_scheduler.sv
// Frequency-hop sequencer for the DDS I/Q core: single tone, one-shot or looping FTW sweep,
// holding each FTW for a programmed dwell while generating the PRT RF gate.
module dds_hop_scheduler #(
  parameter int FTW_W = 32,
  parameter int CNT_W = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk_user_bufg,
  input  logic             rst_glb,
  input  logic             start,
  input  logic             stop_req,
  input  logic [1:0]       cfg_mode,
  input  logic [FTW_W-1:0] cfg_start_ftw,
  input  logic [FTW_W-1:0] cfg_stop_ftw,
  input  logic [FTW_W-1:0] cfg_step_ftw,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic [CNT_W-1:0] cfg_prt_width,
  input  logic [CNT_W-1:0] cfg_prt_cycle,
  output logic [FTW_W-1:0] dds_ftw_o,
  output logic             dds_ftw_valid,
  input  logic             dds_ftw_ready,
  output logic             rf_gate,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] hop_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DWELL, S_DONE} state_e;
  typedef enum logic [1:0] {M_TONE, M_ONCE, M_LOOP} mode_e;
  typedef enum logic [1:0] {G_PAT, G_HIGH, G_LOW} gate_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  gate_e            gmode_q, gmode_d;
  logic [FTW_W-1:0] start_ftw_q, start_ftw_d;
  logic [FTW_W-1:0] stop_ftw_q, stop_ftw_d;
  logic [FTW_W-1:0] step_ftw_q, step_ftw_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] prt_width_q, prt_width_d;
  logic [CNT_W-1:0] prt_cycle_q, prt_cycle_d;
  logic [FTW_W-1:0] ftw_q, ftw_d;
  logic             valid_q, valid_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] hop_idx_q, hop_idx_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0] prt_cnt_q, prt_cnt_d;

  logic [FTW_W:0]   nxt_sum;
  logic             last_dwell;
  logic [CNT_W-1:0] prt_inc;

  function automatic logic gate_at(input gate_e gm, input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] width);
    gate_at = (gm == G_HIGH) || ((gm == G_PAT) && (cnt < width));
  endfunction

  assign nxt_sum    = {1'b0, ftw_q} + {1'b0, step_ftw_q};
  assign last_dwell = (dwell_cnt_q == dwell_q - CNT_ONE);
  assign prt_inc    = (prt_cnt_q == prt_cycle_q - CNT_ONE) ? '0 : prt_cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    gmode_d     = gmode_q;
    start_ftw_d = start_ftw_q;
    stop_ftw_d  = stop_ftw_q;
    step_ftw_d  = step_ftw_q;
    dwell_d     = dwell_q;
    prt_width_d = prt_width_q;
    prt_cycle_d = prt_cycle_q;
    ftw_d       = ftw_q;
    valid_d     = valid_q;
    gate_d      = 1'b0;
    done_d      = 1'b0;
    hop_idx_d   = hop_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    prt_cnt_d   = prt_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop_req) begin
          start_ftw_d = cfg_start_ftw;
          stop_ftw_d  = cfg_stop_ftw;
          step_ftw_d  = cfg_step_ftw;
          dwell_d     = (cfg_dwell == '0) ? CNT_ONE : cfg_dwell;
          prt_width_d = cfg_prt_width;
          prt_cycle_d = cfg_prt_cycle;
          // A zero step can never advance, so it degenerates to a single tone.
          if (cfg_step_ftw == '0 || cfg_mode == 2'd0 || cfg_mode == 2'd3) mode_d = M_TONE;
          else if (cfg_mode == 2'd1)                                       mode_d = M_ONCE;
          else                                                             mode_d = M_LOOP;
          if (cfg_prt_width == '0)                                         gmode_d = G_LOW;
          else if (cfg_prt_cycle == '0 || cfg_prt_width >= cfg_prt_cycle)  gmode_d = G_HIGH;
          else                                                             gmode_d = G_PAT;
          ftw_d     = cfg_start_ftw;
          valid_d   = 1'b1;
          hop_idx_d = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dds_ftw_ready) begin
          hop_idx_d   = hop_idx_q + IDX_ONE;
          valid_d     = 1'b0;
          dwell_cnt_d = '0;
          prt_cnt_d   = '0;
          gate_d      = gate_at(gmode_q, '0, prt_width_q);
          state_d     = S_DWELL;
        end
      end
      S_DWELL: begin
        if (!last_dwell || mode_q == M_TONE) begin
          dwell_cnt_d = last_dwell ? '0 : dwell_cnt_q + CNT_ONE;
          prt_cnt_d   = prt_inc;
          gate_d      = gate_at(gmode_q, prt_inc, prt_width_q);
        end else if (!nxt_sum[FTW_W] && nxt_sum[FTW_W-1:0] <= stop_ftw_q) begin
          ftw_d   = nxt_sum[FTW_W-1:0];
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end else if (mode_q == M_LOOP) begin
          ftw_d   = start_ftw_q;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything except the last FTW and hop count.
    if (stop_req && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      gate_d  = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_user_bufg or negedge rst_glb) begin
    if (!rst_glb) begin
      state_q     <= S_IDLE;
      mode_q      <= M_TONE;
      gmode_q     <= G_PAT;
      start_ftw_q <= '0;
      stop_ftw_q  <= '0;
      step_ftw_q  <= '0;
      dwell_q     <= '0;
      prt_width_q <= '0;
      prt_cycle_q <= '0;
      ftw_q       <= '0;
      valid_q     <= 1'b0;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hop_idx_q   <= '0;
      dwell_cnt_q <= '0;
      prt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      gmode_q     <= gmode_d;
      start_ftw_q <= start_ftw_d;
      stop_ftw_q  <= stop_ftw_d;
      step_ftw_q  <= step_ftw_d;
      dwell_q     <= dwell_d;
      prt_width_q <= prt_width_d;
      prt_cycle_q <= prt_cycle_d;
      ftw_q       <= ftw_d;
      valid_q     <= valid_d;
      gate_q      <= gate_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hop_idx_q   <= hop_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      prt_cnt_q   <= prt_cnt_d;
    end
  end

  assign dds_ftw_o     = ftw_q;
  assign dds_ftw_valid = valid_q;
  assign rf_gate       = gate_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign hop_idx       = hop_idx_q;

endmodule

// File: doc/dds_hop_scheduler.md
Name: dds_hop_scheduler

Overview:
- Sequences the frequency tuning word (FTW) fed to the DDS I/Q core.
- Supports three modes: single tone, one-shot sweep and looping sweep.
- Holds each frequency for a programmed dwell and generates the PRT RF gate during that dwell.
- Sits between the VIO/register configuration and the DDS phase accumulator. It uses a valid/ready handshake toward the DDS.

Parameters:
FTW_W, 32, width of tuning words and frequency config.
CNT_W, 32, width of dwell and PRT counters.
IDX_W, 16, width of hop index counter.

Ports:
clk_user_bufg  in  1  DDS user clock.
rst_glb  in  1  async active-low reset.
start  in  1  one-cycle request to begin; sampled only in IDLE.
stop_req  in  1  abort; sampled in every state.
cfg_mode  in  2  0 single tone, 1 sweep once, 2 sweep loop, 3 reserved (treated as 0).
cfg_start_ftw  in  FTW_W  first FTW.
cfg_stop_ftw  in  FTW_W  upper sweep bound, inclusive.
cfg_step_ftw  in  FTW_W  FTW increment per hop.
cfg_dwell  in  CNT_W  cycles held per hop.
cfg_prt_width  in  CNT_W  gate-high cycles per PRT period.
cfg_prt_cycle  in  CNT_W  PRT period in cycles.
dds_ftw_o  out  FTW_W  FTW presented to DDS.
dds_ftw_valid  out  1  FTW valid.
dds_ftw_ready  in  1  DDS accepts FTW.
rf_gate  out  1  PRT gate, active during DWELL only.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse at natural end of a sweep-once run.
hop_idx  out  IDX_W  count of accepted FTWs since start; wraps.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Config latching:
  - All cfg_* inputs are latched on the cycle start is accepted.
  - Changes after that are ignored until the next start.
- Normalisation at latch:
  - dwell 0 becomes 1.
  - prt_cycle 0 means rf_gate is held high for the whole dwell.
  - prt_width >= prt_cycle means rf_gate is held high.
  - prt_width 0 means rf_gate is held low.
  - step 0 forces single-tone behaviour.
- States: IDLE, ISSUE, DWELL, DONE.
- IDLE:
  - start=1 and stop_req=0 at cycle N: latch config, set hop_idx=0, cur=start_ftw.
  - ISSUE with dds_ftw_valid=1 and dds_ftw_o=start_ftw from cycle N+1.
- ISSUE:
  - Hold valid and FTW stable until dds_ftw_ready=1.
  - On the handshake cycle, hop_idx increments and the next state is DWELL.
- DWELL:
  - Runs for exactly dwell cycles. The dwell counter and PRT counter start at 0 on the first DWELL cycle.
  - rf_gate = (prt_cnt < prt_width) as a registered output aligned to DWELL cycles.
  - prt_cnt wraps at prt_cycle-1 and restarts on each new hop.
  - On the last dwell cycle, the next hop is decided as follows.
    - Single tone: stay in DWELL indefinitely. The counters keep running and the PRT keeps repeating. No re-issue.
    - Sweep: compute nxt = cur + step in FTW_W+1 bits. If nxt <= stop (no carry), set cur=nxt and go to ISSUE; valid rises the cycle after the last dwell cycle.
    - Sweep end, when carry is set or nxt > stop:
      - Sweep once: go to DONE.
      - Loop: set cur=start_ftw and go to ISSUE.
- Hop period with ready tied high: dwell + 1 cycles.
- DONE: pulse done for one cycle, then return to IDLE. dds_ftw_o retains the last FTW.
- Start above stop: only start_ftw is issued. After one dwell, sweep once goes to DONE and loop re-issues start_ftw.
- stop_req, in any non-IDLE state:
  - Next state is IDLE; valid, rf_gate and busy go low the next cycle; done is not pulsed.
  - valid may drop mid-handshake; the DDS side tolerates this.
- start and stop_req together in IDLE: stop wins and the block stays IDLE.
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values.

Test Plan:
- Sweep once, start=100, step=50, stop=250, dwell=4, ready=1:
  - FTWs 100, 150, 200, 250, each accepted 5 cycles apart.
  - done pulses once; hop_idx=4; busy low afterwards.
- Loop mode, start=0, step=10, stop=25, dwell=2:
  - FTW sequence 0, 10, 20, 0, 10, ….
  - hop_idx increments on every accept.
- Backpressure: ready low for 7 cycles in ISSUE.
  - valid held and FTW stable for all 7 cycles.
  - Dwell starts the cycle after ready rises.
- PRT gating, dwell=20, prt_width=3, prt_cycle=8:
  - rf_gate pattern 11100000 11100000 1110 per hop.
  - prt_width=0 gives rf_gate always 0; prt_cycle=0 gives rf_gate always 1.
- Overflow, start=0xFFFF_FFF0, step=0x20, stop=0xFFFF_FFFF, sweep once:
  - Only one FTW is issued, then done.
- stop_req asserted during ISSUE with ready=0: valid low and state IDLE next cycle, no done. start together with stop_req in IDLE leaves busy low.
